// File: rtl/ram256x64_arbiter_if.sv
// Requester-side bus of the RAM256x64 arbiter: two request channels,
// their grant/done pulses and the shared read-data return.
interface ram256x64_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [63:0] wdata0;
    logic [63:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [63:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata
    );
endinterface

// File: rtl/ram256x64_arbiter.sv
// Two-requester round-robin arbiter/sequencer driving the RAM256x64 pins.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module ram256x64_arbiter (
    input  logic                      clk,
    input  logic                      rst,
    ram256x64_arbiter_if.slave        bus,
    output logic [63:0]               ram_addr,
    output logic [63:0]               ram_data_in,
    output logic                      ram_wrt,
    input  logic [63:0]               ram_data_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic       win;
    logic [7:0] addr_q;
    logic       any_req;
    logic       pick1;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic       last;
`endif

    always_comb begin
        any_req = bus.req0 | bus.req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        pick1 = bus.req1 & ~bus.req0;
`else
        // on contention the requester that did not win last time goes next
        pick1 = bus.req1 & (~bus.req0 | ~last);
`endif
    end

    assign ram_addr = {addr_q, 56'h0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            win         <= 1'b0;
            addr_q      <= 8'h0;
            ram_data_in <= 64'h0;
            ram_wrt     <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.rdata   <= 64'h0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last        <= 1'b1;
`endif
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            ram_wrt   <= 1'b0;
            unique case (state)
                ACCESS: begin
                    state     <= DONE;
                    bus.done0 <= ~win;
                    bus.done1 <= win;
                    // ram_wrt high here means this slot was a write
                    if (!ram_wrt)
                        bus.rdata <= ram_data_out;
                end
                default: begin
                    if (any_req) begin
                        state       <= ACCESS;
                        win         <= pick1;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last        <= pick1;
`endif
                        addr_q      <= pick1 ? bus.addr1 : bus.addr0;
                        ram_data_in <= pick1 ? bus.wdata1 : bus.wdata0;
                        ram_wrt     <= pick1 ? bus.we1 : bus.we0;
                        bus.gnt0    <= ~pick1;
                        bus.gnt1    <= pick1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram256x64_arbiter.sv
// Self-checking bench for ram256x64_arbiter with a behavioural RAM256x64.
// Vector table for single accesses plus directed multi-cycle sequences.
module tb_ram256x64_arbiter;
    logic        clk;
    logic        rst;
    logic [63:0] ram_addr;
    logic [63:0] ram_data_in;
    logic        ram_wrt;
    logic [63:0] ram_data_out;
    logic [63:0] mem [256];

    int checks = 0;
    int errors = 0;
    logic [63:0] prev_rdata;
    logic [63:0] exp_mem [256];

    ram256x64_arbiter_if bus ();

    ram256x64_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_wrt      (ram_wrt),
        .ram_data_out (ram_data_out)
    );

    always @(posedge clk)
        if (ram_wrt)
            mem[ram_addr[63:56]] <= ram_data_in;

    assign ram_data_out = mem[ram_addr[63:56]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        we;
        logic [7:0]  a;
        logic [63:0] d;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic on, input logic we,
                         input logic [7:0] a, input logic [63:0] d);
        if (!r) begin
            bus.req0 = on; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = on; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // called right after a negedge with both requesters idle
    task automatic xact(input logic r, input logic we, input logic [7:0] a,
                        input logic [63:0] d, input logic [63:0] exp);
        logic [1:0] one;
        one = r ? 2'b10 : 2'b01;
        drive(r, 1'b1, we, a, d);
        @(negedge clk);
        chk("gnt", {bus.gnt1, bus.gnt0}, one);
        chk("done_in_access", {bus.done1, bus.done0}, 2'b00);
        chk("ram_wrt_access", ram_wrt, we);
        chk("ram_addr", ram_addr, {a, 56'h0});
        if (we)
            chk("ram_data_in", ram_data_in, d);
        drive(r, 1'b0, 1'b0, 8'h0, 64'h0);
        @(negedge clk);
        chk("done", {bus.done1, bus.done0}, one);
        chk("gnt_in_done", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("ram_wrt_done", ram_wrt, 1'b0);
        if (!we)
            prev_rdata = exp;
        chk("rdata", bus.rdata, prev_rdata);
        @(negedge clk);
        chk("idle_after", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_rdata = 64'h0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        logic        w;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 64'h0);
        prev_rdata = 64'h0;

        vt[0] = '{1'b0, 1'b1, 8'h05, 64'hDEADBEEF_01234567, 64'h0};
        vt[1] = '{1'b0, 1'b0, 8'h05, 64'h0, 64'hDEADBEEF_01234567};
        vt[2] = '{1'b1, 1'b1, 8'h10, 64'h1111_2222_3333_4444, 64'h0};
        vt[3] = '{1'b0, 1'b1, 8'h20, 64'h5555_6666_7777_8888, 64'h0};
        vt[4] = '{1'b1, 1'b0, 8'h10, 64'h0, 64'h1111_2222_3333_4444};
        vt[5] = '{1'b0, 1'b0, 8'h20, 64'h0, 64'h5555_6666_7777_8888};
        vt[6] = '{1'b1, 1'b1, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
        vt[7] = '{1'b1, 1'b0, 8'hFF, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0};
        vt[8] = '{1'b0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vt[9] = '{1'b0, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

        // reset held two edges, then idle
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_pulses", {bus.gnt1, bus.gnt0, bus.done1, bus.done0},
                4'h0);
            chk("rst_ram_wrt", ram_wrt, 1'b0);
            chk("rst_ram_addr", ram_addr, 64'h0);
            chk("rst_ram_data_in", ram_data_in, 64'h0);
            chk("rst_rdata", bus.rdata, 64'h0);
        end

        for (int i = 0; i < 10; i++)
            xact(vt[i].r, vt[i].we, vt[i].a, vt[i].d, vt[i].exp);

        // contention from reset: requester 0 first
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h10, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 64'h0);
        for (int g = 0; g < 4; g++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = g[0];
`endif
            @(negedge clk);
            chk("cont_gnt", {bus.gnt1, bus.gnt0}, w ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("cont_done", {bus.done1, bus.done0}, w ? 2'b10 : 2'b01);
            chk("cont_rdata", bus.rdata,
                w ? 64'h5555_6666_7777_8888 : 64'h1111_2222_3333_4444);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        @(negedge clk);
        chk("cont_gnt_last", {bus.gnt1, bus.gnt0}, 2'b10);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 64'h0);
        @(negedge clk);
        chk("cont_done_last", {bus.done1, bus.done0}, 2'b10);
        chk("cont_rdata_last", bus.rdata, 64'h5555_6666_7777_8888);
        prev_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);

        // full sweep by requester 1
        for (int a = 0; a < 256; a++) begin
            v = {$urandom, $urandom};
            exp_mem[a] = v;
            xact(1'b1, 1'b1, 8'(a), v, 64'h0);
        end
        for (int a = 0; a < 256; a++)
            xact(1'b1, 1'b0, 8'(a), 64'h0, exp_mem[a]);

        // reset lands on the closing edge of a write ACCESS
        drive(1'b1, 1'b1, 1'b1, 8'h33, 64'h1);
        @(negedge clk);
        chk("rstw_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
        chk("rstw_wrt", ram_wrt, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_rdata = 64'h0;
        chk("rstw_no_done", {bus.done1, bus.done0}, 2'b00);
        chk("rstw_wrt_off", ram_wrt, 1'b0);
        @(negedge clk);
        chk("rstw_no_done2", {bus.done1, bus.done0}, 2'b00);
        xact(1'b0, 1'b0, 8'h33, 64'h0, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/ram256x64_arbiter.md
# ram256x64_arbiter

Two-port arbiter and sequencer for the 256-entry × 64-bit RAM (RAM256x64). It accepts read/write requests from two independent requesters, selects one per slot by round-robin, and drives the RAM's address, write-data and write-enable pins from registers. It returns read data with a valid pulse and acknowledges writes. It is the only driver of the RAM in the datapath.

## Interface
Parameters:
- none; address width 8, data width 64 are fixed by the RAM.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1 each  request from requester 0 / 1
- we0, we1  in  1 each  1 = write, 0 = read; valid with req
- addr0, addr1  in  8 each  word address; valid with req
- wdata0, wdata1  in  64 each  write data; valid with req
- gnt0, gnt1  out  1 each  one-cycle grant pulse; request latched
- done0, done1  out  1 each  one-cycle completion pulse (read data valid or write committed)
- rdata  out  64  read data, valid while done0/done1 is high for a read
- ram_addr  out  64  to RAM addr; bits [63:56] = latched address, bits [55:0] = 0
- ram_data_in  out  64  to RAM data_in
- ram_wrt  out  1  to RAM wrt
- ram_data_out  in  64  from RAM data_out

## Operation
- RAM behaviour: write on rising clk when wrt=1; data_out follows ram_addr combinationally.
- FSM states: IDLE, ACCESS, DONE.
- Arbitration happens at a rising edge when the state is IDLE or DONE and req0|req1 = 1:
  - The winner's we/addr/wdata are latched into ram_wrt/ram_addr/ram_data_in.
  - The winner index is recorded, and the next state is ACCESS.
  - If no request is pending, the next state is IDLE.
- ACCESS lasts one cycle:
  - gnt of the winner = 1; the RAM pins are driven from the latches.
  - For a write, ram_wrt = 1 and the RAM commits at the closing edge.
  - For a read, ram_data_out is registered into rdata at the closing edge.
  - Next state is DONE, unconditionally.
- DONE lasts one cycle:
  - done of the winner = 1; ram_wrt = 0.
  - rdata holds the read result. rdata is unchanged after a write.
  - Arbitration runs at the closing edge, as in IDLE.
- Round-robin: `last` register records the most recent winner. When both requests are pending, the requester ≠ `last` wins. When only one is pending, it wins. `last` updates at each grant.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen; deassert req by the edge closing the gnt cycle unless a new request is intended. A req still high in DONE is treated as a new request.
- ram_addr[55:0] is always 0. Addresses 0..255 map directly; there is no wrap logic.

## Timing
- Reset (rst sampled high at a rising edge) gives, in the next cycle:
  - state IDLE, `last` = 1;
  - gnt0/1 = 0, done0/1 = 0, ram_wrt = 0;
  - ram_addr = 0, ram_data_in = 0, rdata = 0.
- Latency: req sampled at edge k → gnt high in cycle k+1 → done (and rdata for reads) high in cycle k+2.
- Throughput: one access per 2 cycles with back-to-back requests (DONE → ACCESS).
- Reset mid-operation:
  - A write whose ACCESS cycle ends at the reset edge is committed, because the RAM samples wrt at that edge.
  - No done pulse follows; the pending read result is discarded.
- Simultaneous req0 & req1 from reset: requester 0 wins first, because `last` = 1.
- gnt0 & gnt1 are never high together; likewise done0 & done1.

## Configuration
- RAM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Requester 0 always wins when both request; `last` is unused; requester 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then no req → all outputs 0, ram_addr = 0, ram_wrt never 1.
- Single write/read: req0, we0=1, addr0=8'h05, wdata0=64'hDEADBEEF_01234567; then req0 read of 8'h05 → ram_wrt=1 only in the ACCESS cycle; ram_addr = 64'h0500_0000_0000_0000; done0 two cycles after req; rdata = 64'hDEADBEEF_01234567.
- Contention: req0 and req1 held high continuously, reads of 8'h10 / 8'h20 → grants alternate 0,1,0,1, one every 2 cycles; rdata matches the preloaded values.
- Full sweep: requester 1 writes random data to all 256 addresses, then reads them back → all 256 match; address 8'hFF yields ram_addr[63:56] = 8'hFF.
- Reset mid-write: assert rst in the ACCESS cycle of a write of 64'h1 to 8'h33 → no done1; a subsequent read of 8'h33 returns 64'h1.
- With RAM_ARB_FIXED_PRIO_EN: both requesters held high → gnt0 only; gnt1 never asserted until req0 drops.
